// File: rtl/player_pkg.sv
// Shared definitions for the dino player controller.
// Holds the game-state encoding used by the controller FSM and the state width.
package player_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESTART   = 3'd0,
    ST_JUMPING   = 3'd1,
    ST_RUNNING   = 3'd2,
    ST_DUCKING   = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

endpackage

// File: rtl/player_jump_integrator.sv
// Jump physics for the dino player: height and velocity registers.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   clear            zero height and velocity (restart)
//   load             load JUMP_VEL into velocity (jump start, height untouched)
//   step             advance one physics tick (game_tick[1] while jumping)
//   button_up        held level; release caps upward velocity at JUMP_CUT_VEL
//   button_down      held level; selects fast-fall deceleration
//   height           current height above ground
//   land             this step would reach or cross the ground
module player_jump_integrator #(
  parameter int POS_W           = 8,
  parameter int VEL_W           = 6,
  parameter int JUMP_VEL        = 12,
  parameter int GRAVITY         = 1,
  parameter int FAST_FALL_ACCEL = 3,
  parameter int JUMP_CUT_VEL    = 4,
  parameter int MAX_HEIGHT      = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic             button_up,
  input  logic             button_down,
  output logic [POS_W-1:0] height,
  output logic             land
);

  localparam logic signed [VEL_W-1:0] CUT_V  = VEL_W'(JUMP_CUT_VEL);
  localparam logic signed [VEL_W-1:0] JUMP_V = VEL_W'(JUMP_VEL);
  localparam logic signed [VEL_W:0]   GRAV_W = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   FAST_W = (VEL_W+1)'(FAST_FALL_ACCEL);
  localparam logic signed [VEL_W:0]   V_MIN  = (VEL_W+1)'(-(2**(VEL_W-1)));
  localparam logic signed [POS_W+1:0] H_MAX  = (POS_W+2)'(MAX_HEIGHT);

  logic signed [VEL_W-1:0] vel;
  logic signed [VEL_W-1:0] v_eff;
  logic signed [VEL_W:0]   v_eff_w;
  logic signed [VEL_W:0]   dec_w;
  logic signed [VEL_W:0]   v_wide;
  logic signed [VEL_W-1:0] v_next;
  logic signed [POS_W+1:0] sum;
  logic [POS_W-1:0]        h_next;

  always_comb begin
    v_eff   = (!button_up && (vel > CUT_V)) ? CUT_V : vel;
    // Two guard bits: one for the carry above MAX_HEIGHT, one for sign.
    sum     = $signed({2'b00, height}) +
              $signed({{(POS_W+2-VEL_W){v_eff[VEL_W-1]}}, v_eff});
    land    = sum[POS_W+1] || (sum == '0);
    h_next  = (sum > H_MAX) ? H_MAX[POS_W-1:0] : sum[POS_W-1:0];
    v_eff_w = {v_eff[VEL_W-1], v_eff};
    dec_w   = button_down ? FAST_W : GRAV_W;
    v_wide  = v_eff_w - dec_w;
    v_next  = (v_wide < V_MIN) ? V_MIN[VEL_W-1:0] : v_wide[VEL_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      height <= '0;
      vel    <= '0;
    end else if (clear) begin
      height <= '0;
      vel    <= '0;
    end else if (load) begin
      vel    <= JUMP_V;
    end else if (step) begin
      if (land) begin
        height <= '0;
        vel    <= '0;
      end else begin
        height <= h_next;
        vel    <= v_next;
      end
    end
  end

endmodule

// File: rtl/player_motion_controller.sv
// Dino player controller: game-state FSM, up-edge detect, restart lockout
// and registered outputs around the jump integrator.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   game_tick[1:0]    [0] strobe (FSM), then [1] strobe next cycle (physics)
//   button_up/down    debounced levels
//   crash             collision level, sampled on game_tick[0]
//   player_position   height above ground
//   game_start_pulse  RESTART -> JUMPING
//   game_over_pulse   entry to GAME_OVER
//   jump_pulse        any entry to JUMPING
//   jumping/ducking/game_over  registered state flags
module player_motion_controller
  import player_pkg::*;
#(
  parameter int POS_W                 = 8,
  parameter int VEL_W                 = 6,
  parameter int JUMP_VEL              = 12,
  parameter int GRAVITY               = 1,
  parameter int FAST_FALL_ACCEL       = 3,
  parameter int JUMP_CUT_VEL          = 4,
  parameter int MAX_HEIGHT            = 255,
  parameter int RESTART_LOCKOUT_TICKS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       game_tick,
  input  logic             button_up,
  input  logic             button_down,
  input  logic             crash,
  output logic [POS_W-1:0] player_position,
  output logic             game_start_pulse,
  output logic             game_over_pulse,
  output logic             jump_pulse,
  output logic             jumping,
  output logic             ducking,
  output logic             game_over
);

  localparam int LOCK_W = (RESTART_LOCKOUT_TICKS > 0) ? $clog2(RESTART_LOCKOUT_TICKS + 1) : 1;
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(RESTART_LOCKOUT_TICKS);

  state_t            state, state_nxt;
  logic              up_prev;
  logic [LOCK_W-1:0] lockout, lock_nxt;
  logic              tick0, tick1, up_rise;
  logic              load, clear, step, land;
  logic              start_n, over_n, jump_n;

  // A simultaneous [1] is ignored so only the [0] actions take effect.
  assign tick0   = game_tick[0];
  assign tick1   = game_tick[1] & ~game_tick[0];
  assign up_rise = button_up & ~up_prev;
  assign step    = tick1 && (state == ST_JUMPING);

  always_comb begin
    state_nxt = state;
    lock_nxt  = lockout;
    load      = 1'b0;
    clear     = 1'b0;
    start_n   = 1'b0;
    over_n    = 1'b0;
    jump_n    = 1'b0;
    if (tick0) begin
      case (state)
        ST_RESTART: if (up_rise) begin
          state_nxt = ST_JUMPING;
          load      = 1'b1;
          start_n   = 1'b1;
          jump_n    = 1'b1;
        end
        ST_RUNNING: begin
          if (crash)            state_nxt = ST_GAME_OVER;
          else if (button_down) state_nxt = ST_DUCKING;
          else if (button_up) begin
            state_nxt = ST_JUMPING;
            load      = 1'b1;
            jump_n    = 1'b1;
          end
        end
        ST_DUCKING: begin
          if (crash)             state_nxt = ST_GAME_OVER;
          else if (!button_down) state_nxt = ST_RUNNING;
        end
        ST_JUMPING: if (crash) state_nxt = ST_GAME_OVER;
        ST_GAME_OVER: begin
          if (lockout < LOCK_MAX) lock_nxt = lockout + 1'b1;
          else if (up_rise) begin
            state_nxt = ST_RESTART;
            clear     = 1'b1;
            lock_nxt  = '0;
          end
        end
        default: state_nxt = ST_RESTART;
      endcase
      if ((state_nxt == ST_GAME_OVER) && (state != ST_GAME_OVER)) begin
        over_n   = 1'b1;
        lock_nxt = '0;
      end
    end else if (step && land) begin
      state_nxt = ST_RUNNING;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_RESTART;
      up_prev          <= 1'b0;
      lockout          <= '0;
      game_start_pulse <= 1'b0;
      game_over_pulse  <= 1'b0;
      jump_pulse       <= 1'b0;
      jumping          <= 1'b0;
      ducking          <= 1'b0;
      game_over        <= 1'b0;
    end else begin
      state            <= state_nxt;
      lockout          <= lock_nxt;
      if (tick0) up_prev <= button_up;
      game_start_pulse <= start_n;
      game_over_pulse  <= over_n;
      jump_pulse       <= jump_n;
      jumping          <= (state_nxt == ST_JUMPING);
      ducking          <= (state_nxt == ST_DUCKING);
      game_over        <= (state_nxt == ST_GAME_OVER);
    end
  end

  player_jump_integrator #(
    .POS_W           (POS_W),
    .VEL_W           (VEL_W),
    .JUMP_VEL        (JUMP_VEL),
    .GRAVITY         (GRAVITY),
    .FAST_FALL_ACCEL (FAST_FALL_ACCEL),
    .JUMP_CUT_VEL    (JUMP_CUT_VEL),
    .MAX_HEIGHT      (MAX_HEIGHT)
  ) u_integrator (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .load        (load),
    .step        (step),
    .button_up   (button_up),
    .button_down (button_down),
    .height      (player_position),
    .land        (land)
  );

endmodule

// File: tb/tb_player_motion_controller.sv
// Directed bench for player_motion_controller with default parameters.
module tb_player_motion_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] game_tick = 2'b00;
  logic       button_up = 1'b0;
  logic       button_down = 1'b0;
  logic       crash = 1'b0;
  logic [7:0] player_position;
  logic       game_start_pulse, game_over_pulse, jump_pulse;
  logic       jumping, ducking, game_over;

  int n_cmp = 0;
  int n_bad = 0;

  // values captured by frame(): pulses after the [0] edge, the rest after the [1] edge
  logic a_sp, a_op, a_jp, a_pz;
  logic [7:0] a_pos;
  logic a_jmp, a_dck, a_gov;

  typedef struct {
    logic up, down, crash;
    int   pos;
    logic jmp, dck, gov;
    logic sp, op, jp;
  } vec_t;

  vec_t tab[$];

  player_motion_controller dut (
    .clk              (clk),
    .reset            (reset),
    .game_tick        (game_tick),
    .button_up        (button_up),
    .button_down      (button_down),
    .crash            (crash),
    .player_position  (player_position),
    .game_start_pulse (game_start_pulse),
    .game_over_pulse  (game_over_pulse),
    .jump_pulse       (jump_pulse),
    .jumping          (jumping),
    .ducking          (ducking),
    .game_over        (game_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (game_tick != 2'b11) else $error("game_tick phases overlap");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One game frame: [0] strobe cycle, [1] strobe cycle, one idle cycle.
  task automatic frame(input logic up, input logic down, input logic cr);
    @(negedge clk);
    button_up = up; button_down = down; crash = cr; game_tick = 2'b01;
    @(posedge clk); #1;
    a_sp = game_start_pulse; a_op = game_over_pulse; a_jp = jump_pulse;
    @(negedge clk);
    game_tick = 2'b10;
    @(posedge clk); #1;
    a_pos = player_position; a_jmp = jumping; a_dck = ducking; a_gov = game_over;
    a_pz  = game_start_pulse | game_over_pulse | jump_pulse;
    @(negedge clk);
    game_tick = 2'b00; crash = 1'b0;
  endtask

  function automatic vec_t mk(input logic u, d, c, input int p,
                              input logic j, dk, g, s, o, jp);
    vec_t v;
    v.up = u; v.down = d; v.crash = c; v.pos = p;
    v.jmp = j; v.dck = dk; v.gov = g; v.sp = s; v.op = o; v.jp = jp;
    return v;
  endfunction

  initial begin : main
    int cut_h[11] = '{16, 19, 21, 22, 22, 21, 19, 16, 12, 7, 1};
    int ff_h[8]   = '{78, 75, 69, 60, 48, 33, 15, 0};
    logic lk_up[10] = '{1, 0, 1, 0, 1, 0, 0, 1, 0, 1};
    int exp_h;

    // cut jump from RESTART, landing, run/duck, level jump, crash at 33
    tab.push_back(mk(1, 0, 0, 12, 1, 0, 0, 1, 0, 1));
    foreach (cut_h[i]) tab.push_back(mk(0, 0, 0, cut_h[i], 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 0, 0,  0, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 0, 0,  0, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 0, 12, 1, 0, 0, 0, 0, 1));
    tab.push_back(mk(1, 0, 0, 23, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 0, 33, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 33, 0, 0, 1, 0, 1, 0));

    #12;
    check("rst_pos", player_position, 0);
    check("rst_flags", {jumping, ducking, game_over}, 0);
    check("rst_pulses", {game_start_pulse, game_over_pulse, jump_pulse}, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tab[i]) begin
      frame(tab[i].up, tab[i].down, tab[i].crash);
      check($sformatf("v%0d_pos", i), a_pos, tab[i].pos);
      check($sformatf("v%0d_flags", i), {a_jmp, a_dck, a_gov}, {tab[i].jmp, tab[i].dck, tab[i].gov});
      check($sformatf("v%0d_pulses", i), {a_sp, a_op, a_jp}, {tab[i].sp, tab[i].op, tab[i].jp});
      check($sformatf("v%0d_pulse_width", i), a_pz, 0);
    end

    // restart lockout: 8 counted tick0s ignore edges, then a fresh edge restarts
    foreach (lk_up[i]) begin
      frame(lk_up[i], 0, 0);
      if (i < 9) begin
        check($sformatf("lock%0d_gov", i), a_gov, 1);
        check($sformatf("lock%0d_pos", i), a_pos, 33);
      end else begin
        check("lock_restart_gov", a_gov, 0);
        check("lock_restart_pos", a_pos, 0);
        check("lock_restart_pulses", {a_sp, a_op, a_jp}, 0);
      end
    end

    // full jump with up held
    frame(0, 0, 0);
    for (int n = 1; n <= 25; n++) begin
      frame(1, 0, 0);
      exp_h = (n <= 12) ? 12 * n - n * (n - 1) / 2 : 78 - (n - 13) * (n - 12) / 2;
      if (n == 25) exp_h = 0;
      if (n == 1) check("full_start_pulses", {a_sp, a_jp}, 2'b11);
      check($sformatf("full%0d_pos", n), a_pos, exp_h);
      check($sformatf("full%0d_jumping", n), a_jmp, (n < 25));
    end

    // fast fall from the peak
    for (int n = 1; n <= 12; n++) frame(1, 0, 0);
    check("ff_peak", a_pos, 78);
    foreach (ff_h[i]) begin
      frame(1, 1, 0);
      check($sformatf("ff%0d_pos", i), a_pos, ff_h[i]);
    end
    check("ff_landed", a_jmp, 0);
    frame(0, 1, 0);
    check("ff_duck", a_dck, 1);

    // reset mid-jump
    frame(0, 0, 0);
    frame(1, 0, 0);
    check("mid_pos", a_pos, 12);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_pos", player_position, 0);
    check("mid_rst_flags", {jumping, ducking, game_over}, 0);
    @(negedge clk);
    reset = 1'b0;
    frame(0, 0, 0);
    check("post_rst_idle", {a_jmp, a_pos}, 0);
    frame(1, 0, 0);
    check("post_rst_start", {a_sp, a_jp, a_jmp}, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
